fft_output_reorder: RTL and testbench

Sits at the FFT output and takes samples in bit-reversed bin order, one frame of N=2^LOG2N complex samples at a time. It writes each sample into a ping-pong RAM at its bit-reversed address. Each completed frame is read out in natural bin order as a contiguous burst. The block is the drain-side counterpart of the constant-delay pipeline stages: they feed data forward, this block collects and reorders it.

---
 rtl/fft_output_reorder.sv | 129 ++++++++++++
 tb/tb_fft_output_reorder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_reorder.sv
// FFT drain-side reorder buffer: collects bit-reversed frames into a ping-pong
// RAM and plays each completed frame back in natural bin order as one burst.
//
// state | meaning
// IDLE  | no frame pending, outputs invalid
// READ  | streaming bins rd_cnt = 0..N-1 of bank rd_bank
module fft_output_reorder #(
  parameter int LOG2N = 6,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             data_input_en,
  input  logic [WIDTH-1:0] data_input_real,
  input  logic [WIDTH-1:0] data_input_complex,
  output logic             data_output_en,
  output logic [WIDTH-1:0] data_output_real,
  output logic [WIDTH-1:0] data_output_complex,
  output logic             data_output_first,
  output logic             data_output_last
);

  localparam int N = 1 << LOG2N;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  logic [2*WIDTH-1:0] mem [0:2*N-1];

  logic [LOG2N-1:0] wr_cnt;
  logic             wr_bank;
  logic             frame_done;

  rd_state_t        state, state_next;
  logic [LOG2N-1:0] rd_cnt, rd_cnt_next;
  logic             rd_bank, rd_bank_next;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[LOG2N-1-i] = x[i];
    end
    return r;
  endfunction

  assign frame_done = data_input_en && (wr_cnt == '1);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (data_input_en) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (frame_done) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // RAM contents are deliberately left unreset; writes are blocked during reset.
  always_ff @(posedge clock) begin
    if (!reset && data_input_en) begin
      mem[{wr_bank, bitrev(wr_cnt)}] <= {data_input_real, data_input_complex};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_next;
      rd_cnt  <= rd_cnt_next;
      rd_bank <= rd_bank_next;
    end
  end

  always_comb begin
    state_next   = state;
    rd_cnt_next  = rd_cnt;
    rd_bank_next = rd_bank;
    case (state)
      IDLE: begin
        if (frame_done) begin
          state_next   = READ;
          rd_cnt_next  = '0;
          rd_bank_next = wr_bank;
        end
      end
      READ: begin
        rd_cnt_next = rd_cnt + 1'b1;
        if (rd_cnt == '1) begin
          state_next = IDLE;
        end
        // A frame finishing on the burst's last edge chains straight on, keeping output gapless.
        if (frame_done) begin
          state_next   = READ;
          rd_cnt_next  = '0;
          rd_bank_next = wr_bank;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_output_en      <= 1'b0;
      data_output_first   <= 1'b0;
      data_output_last    <= 1'b0;
      data_output_real    <= '0;
      data_output_complex <= '0;
    end else begin
      data_output_en    <= (state == READ);
      data_output_first <= (state == READ) && (rd_cnt == '0);
      data_output_last  <= (state == READ) && (rd_cnt == '1);
      if (state == READ) begin
        {data_output_real, data_output_complex} <= mem[{rd_bank, rd_cnt}];
      end
    end
  end

endmodule

// File: tb/tb_fft_output_reorder.sv
// Scoreboard bench for fft_output_reorder: N=64 instance plus an N=8 instance.
module tb_fft_output_reorder;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic        first;
    logic        last;
    logic        contig;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        in_en = 1'b0;
  logic [15:0] in_re = '0, in_im = '0;
  logic        o_en, o_first, o_last;
  logic [15:0] o_re, o_im;

  logic        in3_en = 1'b0;
  logic [15:0] in3_re = '0, in3_im = '0;
  logic        o3_en, o3_first, o3_last;
  logic [15:0] o3_re, o3_im;

  int n_vec = 0;
  int n_err = 0;
  exp_t q6[$];
  exp_t q3[$];
  logic prev_en6 = 1'b0;
  logic prev_en3 = 1'b0;

  fft_output_reorder #(.LOG2N(6), .WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .data_input_en(in_en), .data_input_real(in_re), .data_input_complex(in_im),
    .data_output_en(o_en), .data_output_real(o_re), .data_output_complex(o_im),
    .data_output_first(o_first), .data_output_last(o_last)
  );

  fft_output_reorder #(.LOG2N(3), .WIDTH(16)) dut3 (
    .clock(clock), .reset(reset),
    .data_input_en(in3_en), .data_input_real(in3_re), .data_input_complex(in3_im),
    .data_output_en(o3_en), .data_output_real(o3_re), .data_output_complex(o3_im),
    .data_output_first(o3_first), .data_output_last(o3_last)
  );

  function automatic int bitrev6(input int k);
    int r = 0;
    for (int i = 0; i < 6; i++) begin
      if (((k >> i) & 1) != 0) r = r | (1 << (5 - i));
    end
    return r;
  endfunction

  function automatic logic [15:0] val(input int tag, input int b);
    return 16'(tag * 64 + b);
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (o_en === 1'b1) begin
      n_vec++;
      if (q6.size() == 0) begin
        n_err++;
        $display("FAIL out64_unexpected: got real=%0d imag=%0d, required no output", o_re, o_im);
      end else begin
        e = q6.pop_front();
        if (o_re !== e.re || o_im !== e.im || o_first !== e.first || o_last !== e.last ||
            (e.contig && !prev_en6)) begin
          n_err++;
          $display("FAIL out64: got re=%0d im=%0d first=%0b last=%0b prev_en=%0b, required re=%0d im=%0d first=%0b last=%0b contig=%0b",
                   o_re, o_im, o_first, o_last, prev_en6, e.re, e.im, e.first, e.last, e.contig);
        end
      end
    end
    prev_en6 = (o_en === 1'b1);
  end

  always @(negedge clock) begin
    exp_t e;
    if (o3_en === 1'b1) begin
      n_vec++;
      if (q3.size() == 0) begin
        n_err++;
        $display("FAIL out8_unexpected: got real=%0d, required no output", o3_re);
      end else begin
        e = q3.pop_front();
        if (o3_re !== e.re || o3_im !== e.im || o3_first !== e.first || o3_last !== e.last ||
            (e.contig && !prev_en3)) begin
          n_err++;
          $display("FAIL out8: got re=%0d im=%0d first=%0b last=%0b prev_en=%0b, required re=%0d im=%0d first=%0b last=%0b",
                   o3_re, o3_im, o3_first, o3_last, prev_en3, e.re, e.im, e.first, e.last);
        end
      end
    end
    prev_en3 = (o3_en === 1'b1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Feeds one 64-bin frame in bit-reversed order; bin b carries real=tag*64+b, imag=-(that).
  task automatic feed6(input int tag, input int gap, input bit contig0, input bit chk_lat,
                       input int n_samples);
    exp_t e;
    int b;
    for (int k = 0; k < n_samples; k++) begin
      b = bitrev6(k);
      in_en = 1'b1;
      in_re = val(tag, b);
      in_im = -val(tag, b);
      @(posedge clock);
      #1;
      in_en = 1'b0;
      if (k != n_samples - 1) idle(gap);
    end
    if (n_samples == 64) begin
      for (int bb = 0; bb < 64; bb++) begin
        e.re     = val(tag, bb);
        e.im     = -val(tag, bb);
        e.first  = (bb == 0);
        e.last   = (bb == 63);
        e.contig = (bb != 0) || contig0;
        q6.push_back(e);
      end
      if (chk_lat) begin
        n_vec++;
        if (o_en !== 1'b0) begin
          n_err++;
          $display("FAIL latency_early tag%0d: en=%0b after edge E, required 0", tag, o_en);
        end
        @(posedge clock);
        #1;
        n_vec++;
        if (o_en !== 1'b1 || o_first !== 1'b1 || o_re !== val(tag, 0)) begin
          n_err++;
          $display("FAIL latency_bin0 tag%0d: en=%0b first=%0b re=%0d after edge E+1, required 1 1 %0d",
                   tag, o_en, o_first, o_re, val(tag, 0));
        end
      end
    end
  endtask

  initial begin
    exp_t e;
    int rev8[8];
    rev8 = '{0, 4, 2, 6, 1, 5, 3, 7};

    // 1: reset with input toggling
    for (int i = 0; i < 3; i++) begin
      in_en = (i % 2 == 0);
      in_re = 16'h1234;
      in3_en = in_en;
      @(posedge clock);
      #1;
      n_vec++;
      if (o_en !== 1'b0 || o_first !== 1'b0 || o_last !== 1'b0 || o_re !== 16'd0 ||
          o_im !== 16'd0 || o3_en !== 1'b0) begin
        n_err++;
        $display("FAIL reset_outputs cyc%0d: en=%0b first=%0b last=%0b re=%0d im=%0d en8=%0b, required all 0",
                 i, o_en, o_first, o_last, o_re, o_im, o3_en);
      end
    end
    in_en = 1'b0;
    in3_en = 1'b0;
    reset = 1'b0;
    idle(80);

    // 2: single contiguous frame
    feed6(0, 0, 1'b0, 1'b1, 64);
    idle(80);

    // 3: three frames back-to-back
    feed6(1, 0, 1'b0, 1'b0, 64);
    feed6(2, 0, 1'b1, 1'b0, 64);
    feed6(3, 0, 1'b1, 1'b0, 64);
    idle(80);

    // 4: one sample every third cycle
    feed6(4, 2, 1'b0, 1'b1, 64);
    idle(80);

    // 5a: partial frame discarded by reset
    feed6(9, 0, 1'b0, 1'b0, 20);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    feed6(5, 0, 1'b0, 1'b1, 64);
    idle(80);

    // 5b: burst truncated by reset
    feed6(6, 0, 1'b0, 1'b1, 64);
    idle(10);
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_vec++;
    if (o_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midburst: en=%0b after reset edge, required 0", o_en);
    end
    q6.delete();
    reset = 1'b0;
    idle(80);

    // 6: N=8 instance
    for (int k = 0; k < 8; k++) begin
      in3_en = 1'b1;
      in3_re = 16'(rev8[k]);
      in3_im = 16'(200 + rev8[k]);
      @(posedge clock);
      #1;
    end
    in3_en = 1'b0;
    for (int b = 0; b < 8; b++) begin
      e.re     = 16'(b);
      e.im     = 16'(200 + b);
      e.first  = (b == 0);
      e.last   = (b == 7);
      e.contig = (b != 0);
      q3.push_back(e);
    end
    idle(20);

    n_vec++;
    if (q6.size() != 0 || q3.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d/%0d expected outputs never appeared, required 0/0", q6.size(), q3.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
